// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - round-robin multi-approach intersection phase scheduler
// Optional macro PREEMPT_EN adds the emergency preemption inputs preempt/preempt_phase.
// Lamp encoding per approach: 001=green, 010=yellow, 100=red.
module traffic_phase_scheduler #(
  parameter int N_PHASES  = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  localparam int PW = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
  localparam int TW = $clog2(MAX_GREEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [N_PHASES-1:0]   sensor,
`ifdef PREEMPT_EN
  input  logic                  preempt,
  input  logic [PW-1:0]         preempt_phase,
`endif
  output logic [3*N_PHASES-1:0] lights,
  output logic [PW-1:0]         active_phase,
  output logic [N_PHASES-1:0]   pending,
  output logic                  phase_start
);

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  state_t                  state_q;
  logic [TW-1:0]           timer_q;
  logic [PW-1:0]           active_q;
  logic [PW-1:0]           next_phase_q;
  logic [N_PHASES-1:0]     pending_q, pending_d;
  logic [3*N_PHASES-1:0]   lights_q;
  logic                    phase_start_q;

  logic [N_PHASES-1:0]     act_oh;
  logic                    others_pending;
  logic [PW-1:0]           scan_phase;
  logic                    scan_found;
  logic                    allred_done, yellow_done, green_exit;
  logic                    gap_out, max_out;
  logic [PW-1:0]           entry_phase, exit_next;

  // All lamps red except the given phase, which shows the given colour.
  function automatic logic [3*N_PHASES-1:0] lamps(input logic [PW-1:0] ph, input logic [2:0] col);
    logic [3*N_PHASES-1:0] r;
    r = {N_PHASES{LAMP_R}};
    r[int'(ph)*3 +: 3] = col;
    return r;
  endfunction

  // One-hot of the active phase and round-robin search for the next requester after it.
  always_comb begin
    act_oh = '0;
    act_oh[active_q] = 1'b1;
    others_pending = |(pending_q & ~act_oh);
    scan_found = 1'b0;
    scan_phase = active_q;
    for (int k = 1; k < N_PHASES; k++) begin
      if (!scan_found && pending_q[PW'((int'(active_q) + k) % N_PHASES)]) begin
        scan_found = 1'b1;
        scan_phase = PW'((int'(active_q) + k) % N_PHASES);
      end
    end
  end

  // State exit conditions; green only yields when someone else is waiting (or preemption forces it).
  always_comb begin
    allred_done = tick && (state_q == S_ALLRED) && (timer_q == TW'(ALLRED_T - 1));
    yellow_done = tick && (state_q == S_YELLOW) && (timer_q == TW'(YELLOW_T - 1));
    gap_out     = (timer_q >= TW'(MIN_GREEN - 1)) && !sensor[active_q];
    max_out     = (timer_q >= TW'(MAX_GREEN - 1));
`ifdef PREEMPT_EN
    green_exit  = tick && (state_q == S_GREEN) &&
                  ((preempt && (preempt_phase != active_q)) ||
                   (!(preempt && (preempt_phase == active_q)) && others_pending && (gap_out || max_out)));
    exit_next   = preempt ? preempt_phase : scan_phase;
    entry_phase = preempt ? preempt_phase : next_phase_q;
`else
    green_exit  = tick && (state_q == S_GREEN) && others_pending && (gap_out || max_out);
    exit_next   = scan_phase;
    entry_phase = next_phase_q;
`endif
  end

  // Latch requests from non-green approaches; entering green clears that phase and beats a same-edge set.
  always_comb begin
    pending_d = pending_q | (sensor & ~((state_q == S_GREEN) ? act_oh : '0));
    if (allred_done) pending_d[entry_phase] = 1'b0;
  end

  // Phase FSM with saturating tick timer and registered lamp/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ALLRED;
      timer_q       <= '0;
      active_q      <= '0;
      next_phase_q  <= '0;
      pending_q     <= '0;
      lights_q      <= {N_PHASES{LAMP_R}};
      phase_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      phase_start_q <= 1'b0;
      if (tick && (timer_q != TW'(MAX_GREEN))) timer_q <= timer_q + 1'b1;
      case (state_q)
        S_ALLRED: begin
`ifdef PREEMPT_EN
          if (preempt) next_phase_q <= preempt_phase;
`endif
          if (allred_done) begin
            state_q       <= S_GREEN;
            timer_q       <= '0;
            active_q      <= entry_phase;
            lights_q      <= lamps(entry_phase, LAMP_G);
            phase_start_q <= 1'b1;
          end
        end
        S_GREEN: begin
          if (green_exit) begin
            state_q      <= S_YELLOW;
            timer_q      <= '0;
            next_phase_q <= exit_next;
            lights_q     <= lamps(active_q, LAMP_Y);
          end
        end
        S_YELLOW: begin
`ifdef PREEMPT_EN
          if (preempt) next_phase_q <= preempt_phase;
`endif
          if (yellow_done) begin
            state_q  <= S_ALLRED;
            timer_q  <= '0;
            lights_q <= {N_PHASES{LAMP_R}};
          end
        end
        default: begin
          state_q  <= S_ALLRED;
          timer_q  <= '0;
          lights_q <= {N_PHASES{LAMP_R}};
        end
      endcase
    end
  end

  assign lights       = lights_q;
  assign active_phase = active_q;
  assign pending      = pending_q;
  assign phase_start  = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - vector table and scoreboard bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  localparam logic [2:0]  G   = 3'b001;
  localparam logic [2:0]  Y   = 3'b010;
  localparam logic [11:0] RED = 12'h924;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b1;
  logic [3:0]  sensor = '0;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic [3:0]  pending;
  logic        phase_start;

  traffic_phase_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .sensor       (sensor),
    .lights       (lights),
    .active_phase (active_phase),
    .pending      (pending),
    .phase_start  (phase_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  sens;
    logic [11:0] lights;
    logic [1:0]  act;
    logic [3:0]  pend;
    logic        start;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [11:0] lamps(input int ph, input logic [2:0] c);
    logic [11:0] r;
    r = RED;
    r[ph*3 +: 3] = c;
    return r;
  endfunction

  task automatic add(input bit r, input logic [3:0] s, input logic [11:0] l,
                     input logic [1:0] a, input logic [3:0] p, input logic st, input int n);
    vec_t v;
    v.rst = r; v.sens = s; v.lights = l; v.act = a; v.pend = p; v.start = st;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] l, input logic [1:0] a,
                       input logic [3:0] p, input logic st);
    n_vec++;
    if (lights !== l || active_phase !== a || pending !== p || phase_start !== st) begin
      n_fail++;
      $display("FAIL %s: got lights=%h act=%0d pend=%b start=%b, want lights=%h act=%0d pend=%b start=%b",
               name, lights, active_phase, pending, phase_start, l, a, p, st);
    end
  endtask

  initial begin
    vec_t e;
    bit   seen_y;

    // Reset release, rest-in-green on phase 0 with no traffic
    add(1, 4'b0000, RED,           0, 4'h0, 0, 1);
    add(0, 4'b0000, RED,           0, 4'h0, 0, 1);
    add(0, 4'b0000, lamps(0, G),   0, 4'h0, 1, 1);
    add(0, 4'b0000, lamps(0, G),   0, 4'h0, 0, 100);
    // Gap-out of phase 0 after sensor[2] pulse, then round-robin from phase 2
    add(1, 4'b0000, RED,           0, 4'h0, 0, 1);
    add(0, 4'b0000, RED,           0, 4'h0, 0, 1);
    add(0, 4'b0000, lamps(0, G),   0, 4'h0, 1, 1);
    add(0, 4'b0100, lamps(0, G),   0, 4'h4, 0, 1);
    add(0, 4'b0000, lamps(0, G),   0, 4'h4, 0, 3);
    add(0, 4'b0000, lamps(0, Y),   0, 4'h4, 0, 3);
    add(0, 4'b0000, RED,           0, 4'h4, 0, 2);
    add(0, 4'b0000, lamps(2, G),   2, 4'h0, 1, 1);
    add(0, 4'b1010, lamps(2, G),   2, 4'hA, 0, 1);
    add(0, 4'b0000, lamps(2, G),   2, 4'hA, 0, 3);
    add(0, 4'b0000, lamps(2, Y),   2, 4'hA, 0, 3);
    add(0, 4'b0000, RED,           2, 4'hA, 0, 2);
    add(0, 4'b0000, lamps(3, G),   3, 4'h2, 1, 1);
    add(0, 4'b0000, lamps(3, G),   3, 4'h2, 0, 4);
    add(0, 4'b0000, lamps(3, Y),   3, 4'h2, 0, 3);
    add(0, 4'b0000, RED,           3, 4'h2, 0, 2);
    add(0, 4'b0000, lamps(1, G),   1, 4'h0, 1, 1);
    add(0, 4'b0000, lamps(1, G),   1, 4'h0, 0, 5);
    // Max-out of phase 0 with sensor[0] held, re-request, and return to phase 0
    add(1, 4'b0001, RED,           0, 4'h0, 0, 1);
    add(0, 4'b0001, RED,           0, 4'h1, 0, 1);
    add(0, 4'b0001, lamps(0, G),   0, 4'h0, 1, 1);
    add(0, 4'b0011, lamps(0, G),   0, 4'h2, 0, 1);
    add(0, 4'b0001, lamps(0, G),   0, 4'h2, 0, 18);
    add(0, 4'b0001, lamps(0, Y),   0, 4'h2, 0, 1);
    add(0, 4'b0001, lamps(0, Y),   0, 4'h3, 0, 2);
    add(0, 4'b0001, RED,           0, 4'h3, 0, 2);
    add(0, 4'b0000, lamps(1, G),   1, 4'h1, 1, 1);
    add(0, 4'b0000, lamps(1, G),   1, 4'h1, 0, 4);
    add(0, 4'b0000, lamps(1, Y),   1, 4'h1, 0, 3);
    add(0, 4'b0000, RED,           1, 4'h1, 0, 2);
    add(0, 4'b0000, lamps(0, G),   0, 4'h0, 1, 1);
    add(0, 4'b0000, lamps(0, G),   0, 4'h0, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n  = !tbl[i].rst;
      sensor = tbl[i].sens;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d", i), e.lights, e.act, e.pend, e.start);
    end

    // Asynchronous reset asserted in the middle of a yellow interval
    @(negedge clk);
    rst_n = 1'b0; sensor = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1; sensor = 4'b0010;
    @(negedge clk);
    sensor = 4'b0000;
    seen_y = 1'b0;
    for (int c = 0; c < 40 && !seen_y; c++) begin
      @(posedge clk);
      #1;
      if (lights[2:0] == Y) seen_y = 1'b1;
    end
    n_vec++;
    if (!seen_y) begin
      n_fail++;
      $display("FAIL yellow_reached: got lamp0=%b, want %b within 40 cycles", lights[2:0], Y);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", RED, 0, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_red", RED, 0, 4'h0, 0);
    @(posedge clk);
    #1;
    check("post_reset_green", lamps(0, G), 0, 4'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Multi-approach intersection controller that shares one green right-of-way among N_PHASES requesting approaches. Each approach has a sensor and a 3-bit lamp output, with the same lamp encoding as the existing two-road controller: 001=G, 010=Y, 100=R. Phase 0 is the main road, and the controller rests in green there when idle. Service order is round-robin, with green timing driven by min-green, gap-out and max-out.

Parameters:
N_PHASES, 4, number of approaches (2..8)
MIN_GREEN, 5, minimum green duration in ticks
MAX_GREEN, 20, maximum green duration when other phases are pending, in ticks
YELLOW_T, 3, yellow duration in ticks
ALLRED_T, 2, all-red clearance in ticks (also used as the post-reset clearance)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  timing strobe, one-cycle pulse (e.g. 1 Hz); all timers advance only on clk edges with tick=1
sensor  input  N_PHASES  per-approach vehicle presence (level), bit i = phase i
lights  output  3*N_PHASES  lamps; bits [3i+2:3i] = phase i
active_phase  output  clog2(N_PHASES)  phase currently holding right-of-way
pending  output  N_PHASES  latched, not-yet-served requests
phase_start  output  1  one-cycle pulse on the cycle a phase enters GREEN

Behaviour:
- Reset (async assert): all lights=100, active_phase=0, pending=0, phase_start=0, state=ALLRED, timer=0. Outputs go red immediately, not at the next edge.
- States: ALLRED -> GREEN -> YELLOW -> ALLRED.
- All outputs are registered. Lamp outputs change on the same edge as the state register. Only active_phase is ever non-red.
- Timer: counts ticks in the current state and clears on state entry. Width is clog2(MAX_GREEN+1), and it saturates, never wraps.
- The state exits on the edge where tick=1 and timer==DUR-1, so a state lasts exactly DUR ticks.
- ALLRED: lasts ALLRED_T ticks, then GREEN on next_phase. After reset, next_phase=0.
- GREEN entry: phase_start=1 for one cycle, and pending[active] is cleared. If a set and a clear hit the same bit on the same edge, the clear wins.
- Request latching: pending[i] is set while sensor[i]=1 and phase i is not in GREEN. The sensor of the green phase is not latched.
- GREEN exit decision is evaluated only when at least one other pending bit is set:
  - gap-out: timer>=MIN_GREEN-1 and sensor[active]=0, on a tick edge -> YELLOW.
  - max-out: timer==MAX_GREEN-1 on a tick edge -> YELLOW, regardless of sensor.
  - No other pending bit: stay GREEN indefinitely (rest-in-green). The timer saturates.
- Max-out re-request: sensor[active] still 1 at max-out sets pending[active] on the next edge, so the phase is served again in rotation.
- next_phase: captured on the GREEN->YELLOW edge as the first set pending bit scanning active+1, active+2, … modulo N_PHASES. Requests arriving during YELLOW/ALLRED do not change it; they wait for the next rotation.
- YELLOW: lasts YELLOW_T ticks; active lamp=010. Then ALLRED (all 100), then active_phase<=next_phase.
- tick held at 1 continuously makes all durations clock-cycle counts. tick=0 freezes all timers, but sensors are still latched.
- Mid-operation reset: immediate all-red; pending cleared; restart with ALLRED_T then phase 0 green.

Optional Feature:
Macro PREEMPT_EN. When defined, two ports are added:
- preempt (input, 1): emergency vehicle detected.
- preempt_phase (input, clog2(N_PHASES)): phase to serve.

Behaviour with PREEMPT_EN defined:
- preempt=1 while in GREEN on a different phase: go to YELLOW at the next tick edge, ignoring MIN_GREEN.
- next_phase<=preempt_phase; pending state is preserved.
- preempt=1 in YELLOW/ALLRED: next_phase is overridden to preempt_phase.
- While preempt=1 and preempt_phase is green, the phase holds green (no max-out). Normal operation resumes when preempt drops.

Without PREEMPT_EN: the ports and logic are absent, and behaviour is exactly as above.

Test Plan:
- All tests use defaults and tick=1 constantly.
- Reset release at t0: lights=100_100_100_100 for 2 cycles, then phase 0 = 001, phase_start pulses, active_phase=0.
- No sensors for 100 cycles after phase 0 green: phase 0 stays 001, pending=0.
- 1-cycle pulse on sensor[2] at green cycle 1, sensor[0]=0:
  - pending=0100.
  - Phase 0 green lasts 5 cycles, then 010 for 3 cycles, then all 100 for 2 cycles.
  - Phase 2 then =001 and pending=0000.
- sensor[0] held 1, sensor[1] pulsed: phase 0 green lasts exactly 20 cycles (max-out). Then phase 1 green, and pending[0]=1.
- Phase 2 green, then sensor[1] and sensor[3] pulsed together: after phase 2 gaps out, phase 3 is served before phase 1.
- rst_n pulled low mid-YELLOW: all lamps 100 within the same cycle (async), pending=0. After release, 2 cycles all-red, then phase 0 green.
